pwm_capture: RTL



---
 rtl/pwm_capture.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// Input-capture peripheral: measures high time and rise-to-rise period of pwm_i in prescaled ticks.
// Latency: 2-flop synchronizer plus edge detect; bus read data and acknowledge one cycle after the strobe.
// Backpressure: none; every access is acknowledged next cycle, a new capture overwrites unread results.
module pwm_capture #(
    parameter int unsigned PRESC_DIV = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pwm_i,
    input  logic [31:0] addr_32b_i,
    input  logic        wren_i,
    input  logic        rden_i,
    input  logic [31:0] din_32b_i,
    output logic [31:0] dout_32b_o,
    output logic        dout_32b_valid_o,
    output logic        interrupt_o
);

    localparam int unsigned   PW        = $clog2(PRESC_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_HIGH   = 2'd2;
    localparam logic [1:0] REG_PERIOD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              hist_q, hist_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  high_tmp_q, high_tmp_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              en_q, en_d;
    logic              irq_en_q, irq_en_d;
    logic              inv_q, inv_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;

    logic              pwm_s;
    logic              rise;
    logic              fall;
    logic              tick;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_sat;
    logic              cap_set;
    logic              ovf_set;
    logic [1:0]        reg_sel;
    logic [31:0]       rdata;
    logic              w1c_valid;
    logic              w1c_ovf;

    // Address/data bits outside the decoded fields carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{addr_32b_i[31:4], addr_32b_i[1:0], din_32b_i[31:3]};

    // Synchronize the pin, apply polarity, and derive single-cycle edge pulses.
    always_comb begin
        sync1_d = pwm_i;
        sync2_d = sync1_q;
        pwm_s   = sync2_q ^ inv_q;
        hist_d  = pwm_s;
        rise    = pwm_s & ~hist_q;
        fall    = ~pwm_s & hist_q;
    end

    // Prescaler restarts on every rise so tick boundaries line up with the measured pulse.
    always_comb begin
        tick = (presc_q == PRESC_MAX);
        if (!en_q || rise || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Measurement FSM: the edge cycle's own tick is included so results are exact floors.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_tmp_d = high_tmp_q;
        high_d     = high_q;
        period_d   = period_q;
        cap_set    = 1'b0;
        ovf_set    = 1'b0;
        cnt_inc    = tick ? (cnt_q + CNT_W'(1)) : cnt_q;
        cnt_sat    = tick && (&cnt_q);
        if (!en_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end
                end
                ST_HIGH: begin
                    if (cnt_sat) begin
                        ovf_set = 1'b1;
                        state_d = ST_IDLE;
                    end else if (fall) begin
                        high_tmp_d = cnt_inc;
                        cnt_d      = cnt_inc;
                        state_d    = ST_LOW;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_LOW: begin
                    if (cnt_sat) begin
                        ovf_set = 1'b1;
                        state_d = ST_IDLE;
                    end else if (rise) begin
                        high_d   = high_tmp_q;
                        period_d = cnt_inc;
                        cap_set  = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Register file, status set/clear (hardware set wins) and registered read port.
    always_comb begin
        reg_sel    = addr_32b_i[3:2];
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        inv_d      = inv_q;
        if (wren_i && (reg_sel == REG_CTRL)) begin
            en_d     = din_32b_i[0];
            irq_en_d = din_32b_i[1];
            inv_d    = din_32b_i[2];
        end
        w1c_valid  = wren_i && (reg_sel == REG_STATUS) && din_32b_i[0];
        w1c_ovf    = wren_i && (reg_sel == REG_STATUS) && din_32b_i[1];
        valid_d    = cap_set | (valid_q & ~w1c_valid);
        ovf_d      = ovf_set | (ovf_q & ~w1c_ovf);
        case (reg_sel)
            REG_CTRL:   rdata = {29'd0, inv_q, irq_en_q, en_q};
            REG_STATUS: rdata = {30'd0, ovf_q, valid_q};
            REG_HIGH:   rdata = 32'(high_q);
            default:    rdata = 32'(period_q);
        endcase
        dout_vld_d = wren_i | rden_i;
        dout_d     = (rden_i && !wren_i) ? rdata : dout_q;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and register state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            presc_q    <= '0;
            cnt_q      <= '0;
            high_tmp_q <= '0;
            high_q     <= '0;
            period_q   <= '0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            inv_q      <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hist_q     <= hist_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            high_tmp_q <= high_tmp_d;
            high_q     <= high_d;
            period_q   <= period_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            inv_q      <= inv_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign dout_32b_o       = dout_q;
    assign dout_32b_valid_o = dout_vld_q;
    assign interrupt_o      = irq_en_q & (valid_q | ovf_q);

endmodule
